// File: rtl/echo_peak_detector.sv
// Echo peak detector: after a start pulse, skips a ring-down blanking interval, then
// searches a fixed window of valid samples for the largest magnitude above a threshold.
module echo_peak_detector #(
  parameter int DATA_W     = 32,
  parameter int IDX_W      = 16,
  parameter int BLANK_LEN  = 64,
  parameter int WINDOW_LEN = 4096
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] threshold,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [DATA_W-1:0] peak_mag,
  output logic [IDX_W-1:0]  peak_idx,
  output logic [1:0]        dbg_state
);

  // Input handshake: a sample is accepted on every rising edge where in_valid=1;
  // there is no backpressure, the block consumes at most one sample per cycle.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BLANK  = 2'd1,
    S_SEARCH = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [DATA_W-1:0] MAX_POS    = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MOST_NEG   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]  BLANK_LAST = IDX_W'(BLANK_LEN - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(BLANK_LEN + WINDOW_LEN - 1);
  localparam state_t            FIRST_ST   = (BLANK_LEN == 0) ? S_SEARCH : S_BLANK;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_thr;
  logic                r_busy;
  logic                r_done;
  logic                r_found;
  logic [DATA_W-1:0]   r_peak_mag;
  logic [IDX_W-1:0]    r_peak_idx;

  logic [DATA_W-1:0]   w_mag;
  logic                w_hit;

  // The most-negative code has no positive twin, so it saturates to the largest positive.
  always_comb begin
    w_mag = in_data;
    if (in_data == MOST_NEG) begin
      w_mag = MAX_POS;
    end else if (in_data[DATA_W-1]) begin
      w_mag = -in_data;
    end
  end

  // Strict compare on the running peak keeps the earliest of equal magnitudes.
  assign w_hit = (w_mag > r_thr) && (w_mag > r_peak_mag);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_thr      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_found    <= 1'b0;
      r_peak_mag <= '0;
      r_peak_idx <= '0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        // Restart from any state; a sample arriving with start is not counted.
        r_state    <= FIRST_ST;
        r_busy     <= 1'b1;
        r_idx      <= '0;
        r_thr      <= threshold;
        r_found    <= 1'b0;
        r_peak_mag <= '0;
        r_peak_idx <= '0;
      end else begin
        case (r_state)
          S_BLANK: begin
            if (in_valid) begin
              r_idx <= r_idx + 1'b1;
              if (r_idx == BLANK_LAST) begin
                r_state <= S_SEARCH;
              end
            end
          end
          S_SEARCH: begin
            if (in_valid) begin
              r_idx <= r_idx + 1'b1;
              if (w_hit) begin
                r_peak_mag <= w_mag;
                r_peak_idx <= r_idx;
                r_found    <= 1'b1;
              end
              if (r_idx == LAST_IDX) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign found     = r_found;
  assign peak_mag  = r_peak_mag;
  assign peak_idx  = r_peak_idx;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_echo_peak_detector.sv
// Bench for echo_peak_detector: directed vector table, hand-written corner sequences,
// and random measurements checked against a window-level reference model.
module tb_echo_peak_detector;

  localparam int DW = 32;
  localparam int IW = 16;
  localparam int BL = 4;
  localparam int WL = 8;
  localparam int NS = BL + WL;

  // clock / reset
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          reset;
  logic          start;
  logic [DW-1:0] threshold;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          busy;
  logic          done;
  logic          found;
  logic [DW-1:0] peak_mag;
  logic [IW-1:0] peak_idx;
  logic [1:0]    dbg_state;

  echo_peak_detector #(
    .DATA_W(DW), .IDX_W(IW), .BLANK_LEN(BL), .WINDOW_LEN(WL)
  ) dut (
    .CLK(CLK), .reset(reset), .start(start), .threshold(threshold),
    .in_data(in_data), .in_valid(in_valid), .busy(busy), .done(done),
    .found(found), .peak_mag(peak_mag), .peak_idx(peak_idx), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] cur_s [NS];
  logic [DW+IW:0] exp_q [$];

  typedef struct {
    logic [DW-1:0] thr;
    logic [DW-1:0] s [NS];
    int            gap;
    logic          ef;
    logic [DW-1:0] em;
    logic [IW-1:0] ei;
  } vec_t;

  vec_t tbl [5];

  // scoreboard compare
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: scan the search window with the magnitude/threshold/tie rules
  function automatic void model(input logic [DW-1:0] thr, output logic f,
                                output logic [DW-1:0] m, output logic [IW-1:0] ix);
    longint best;
    best = 0;
    f    = 1'b0;
    ix   = '0;
    for (int k = BL; k < NS; k++) begin
      longint v;
      longint a;
      v = longint'($signed(cur_s[k]));
      a = (v < 0) ? -v : v;
      if (a > 64'h7FFF_FFFF) a = 64'h7FFF_FFFF;
      if (a > longint'(thr) && a > best) begin
        best = a;
        ix   = IW'(k);
        f    = 1'b1;
      end
    end
    m = DW'(best);
  endfunction

  // driver tasks: each starts and ends 1 time unit after a rising edge
  task automatic pulse_start(input logic [DW-1:0] thr);
    start     = 1'b1;
    threshold = thr;
    in_valid  = 1'b1;
    in_data   = 32'h7FFF_FFF0;
    @(posedge CLK); #1;
    start     = 1'b0;
    in_valid  = 1'b0;
    threshold = $urandom;
  endtask

  task automatic feed(input logic [DW-1:0] d, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      @(posedge CLK); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic finish_feed(input int gap, input logic ef, input logic [DW-1:0] em,
                             input logic [IW-1:0] ei, input string nm);
    for (int k = 0; k < NS; k++) feed(cur_s[k], gap);
    chk({nm, " done"}, done, 1'b1);
    chk({nm, " found"}, found, ef);
    chk({nm, " peak_mag"}, peak_mag, em);
    chk({nm, " peak_idx"}, peak_idx, ei);
    chk({nm, " busy_end"}, busy, 1'b0);
    @(posedge CLK); #1;
    chk({nm, " done_1cyc"}, done, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    chk({nm, " held_mag"}, peak_mag, em);
    chk({nm, " held_idx"}, peak_idx, ei);
  endtask

  initial begin
    logic          f;
    logic [DW-1:0] m;
    logic [IW-1:0] ix;
    logic [DW+IW:0] e;

    tbl[0].thr = 100;  tbl[0].gap = 0; tbl[0].ef = 1'b1; tbl[0].em = 300; tbl[0].ei = 6;
    tbl[0].s   = '{5000, 0, 0, 0, 10, 200, -300, 50, 0, 0, 0, 0};
    tbl[1].thr = 1000; tbl[1].gap = 0; tbl[1].ef = 1'b0; tbl[1].em = 0;   tbl[1].ei = 0;
    tbl[1].s   = '{5000, 0, 0, 0, 10, 200, -300, 50, 0, 0, 0, 0};
    tbl[2].thr = 0;    tbl[2].gap = 0; tbl[2].ef = 1'b1; tbl[2].em = 32'h7FFF_FFFF; tbl[2].ei = 7;
    tbl[2].s   = '{0, 0, 0, 0, 0, 400, 0, 32'h8000_0000, 0, -400, 0, 0};
    tbl[3].thr = 0;    tbl[3].gap = 0; tbl[3].ef = 1'b1; tbl[3].em = 400; tbl[3].ei = 5;
    tbl[3].s   = '{0, 0, 0, 0, 0, 400, 0, 0, 0, -400, 0, 0};
    tbl[4].thr = 100;  tbl[4].gap = 2; tbl[4].ef = 1'b1; tbl[4].em = 300; tbl[4].ei = 6;
    tbl[4].s   = '{5000, 0, 0, 0, 10, 200, -300, 50, 0, 0, 0, 0};

    reset = 1'b0; start = 1'b0; in_valid = 1'b0; threshold = '0; in_data = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst found", found, 1'b0);
    chk("rst peak_mag", peak_mag, 0);
    chk("rst peak_idx", peak_idx, 0);
    chk("rst state", dbg_state, 2'd0);
    reset = 1'b1;
    @(posedge CLK); #1;

    // no start: valid traffic must not wake the block
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      in_data  = $urandom;
      @(posedge CLK); #1;
      chk("idle flags", {busy, done, found}, 3'b000);
      chk("idle peak_mag", peak_mag, 0);
    end
    in_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      cur_s = tbl[i].s;
      pulse_start(tbl[i].thr);
      chk($sformatf("tbl%0d busy", i), busy, 1'b1);
      finish_feed(tbl[i].gap, tbl[i].ef, tbl[i].em, tbl[i].ei, $sformatf("tbl%0d", i));
    end

    // start during the DONE cycle
    cur_s = tbl[0].s;
    pulse_start(100);
    for (int k = 0; k < NS; k++) feed(cur_s[k], 0);
    chk("sdone done", done, 1'b1);
    pulse_start(1000);
    chk("sdone done_clr", done, 1'b0);
    chk("sdone busy", busy, 1'b1);
    chk("sdone found_clr", found, 1'b0);
    chk("sdone mag_clr", peak_mag, 0);
    finish_feed(0, 1'b0, 0, 0, "sdone2");

    // start coinciding with the last window sample
    pulse_start(100);
    for (int k = 0; k < NS - 1; k++) feed(cur_s[k], 0);
    chk("slast pre_mag", peak_mag, 300);
    start = 1'b1; threshold = 100; in_valid = 1'b1; in_data = cur_s[NS-1];
    @(posedge CLK); #1;
    start = 1'b0; in_valid = 1'b0;
    chk("slast no_done", done, 1'b0);
    chk("slast busy", busy, 1'b1);
    chk("slast mag_clr", peak_mag, 0);
    finish_feed(0, 1'b1, 300, 6, "slast2");

    // restart at idx6 of SEARCH
    cur_s = '{0, 0, 0, 0, 0, 5000, 0, 0, 0, 0, 0, 0};
    pulse_start(100);
    for (int k = 0; k < 6; k++) feed(cur_s[k], 0);
    chk("rstrt pre_mag", peak_mag, 5000);
    chk("rstrt pre_idx", peak_idx, 5);
    pulse_start(100);
    chk("rstrt found_clr", found, 1'b0);
    chk("rstrt mag_clr", peak_mag, 0);
    chk("rstrt idx_clr", peak_idx, 0);
    cur_s = tbl[0].s;
    finish_feed(0, 1'b1, 300, 6, "rstrt2");

    // asynchronous reset mid-SEARCH
    cur_s = '{0, 0, 0, 0, 0, 5000, 0, 0, 0, 0, 0, 0};
    pulse_start(0);
    for (int k = 0; k < 7; k++) feed(cur_s[k], 0);
    chk("areset pre_found", found, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("areset flags", {busy, done, found}, 3'b000);
    chk("areset mag", peak_mag, 0);
    chk("areset idx", peak_idx, 0);
    chk("areset state", dbg_state, 2'd0);
    @(posedge CLK); #1;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_data  = 32'h0001_0000;
      @(posedge CLK); #1;
      chk("areset idle", {busy, done, found}, 3'b000);
    end
    in_valid = 1'b0;

    // random measurements against the model
    for (int t = 0; t < 40; t++) begin
      logic [DW-1:0] thr;
      int gap;
      thr = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 1500));
      for (int k = 0; k < NS; k++) begin
        case ($urandom_range(0, 5))
          0: cur_s[k] = '0;
          1: cur_s[k] = 32'h8000_0000;
          2: cur_s[k] = DW'($urandom_range(0, 4000)) - 32'd2000;
          3: cur_s[k] = $urandom;
          4: cur_s[k] = (k > 0) ? cur_s[k-1] : 32'd700;
          default: cur_s[k] = (k > 0) ? -cur_s[k-1] : 32'hFFFF_F000;
        endcase
      end
      gap = $urandom_range(0, 2);
      model(thr, f, m, ix);
      exp_q.push_back({f, m, ix});
      pulse_start(thr);
      e = exp_q.pop_front();
      finish_feed(gap, e[DW+IW], e[DW+IW-1:IW], e[IW-1:0], $sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
